// File: rtl/duty_ramp_controller.sv
// Slews the PS-PWM duty toward target at presc/step rate; d1/d2 latch only at the carrier valley.
// Latency: at most (presc+1)*CARRIER_PERIOD clocks per step. No backpressure: free-running carrier.
module duty_ramp_controller #(
  parameter int DW             = 6,
  parameter int CARRIER_PERIOD = 126,
  parameter int PRESC_W        = 8
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               en,
  input  logic [DW-1:0]      target,
  input  logic [2:0]         step,
  input  logic [PRESC_W-1:0] presc,
  input  logic [2:0]         bal_off,
  output logic [DW-1:0]      d1,
  output logic [DW-1:0]      d2,
  output logic               upd_strobe,
  output logic               at_target,
  output logic               busy
);

  localparam int CW = $clog2(CARRIER_PERIOD);
  localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_PERIOD - 1);
  localparam logic signed [DW+1:0] DUTY_MAX = (DW+2)'((1 << DW) - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        car_cnt_q, car_cnt_d;
  logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
  logic [DW-1:0]        duty_q, duty_d;
  logic [DW-1:0]        d1_q, d1_d;
  logic [DW-1:0]        d2_q, d2_d;
  logic                 upd_strobe_q, upd_strobe_d;

  logic                 boundary;
  logic                 tick;
  logic signed [DW:0]   diff;
  logic signed [DW:0]   mag;
  logic signed [DW:0]   step_s;
  logic signed [DW:0]   inc;
  logic signed [DW+1:0] bal_ext;
  logic signed [DW+1:0] d2_sum;
  logic [DW-1:0]        d2_clamped;

  assign boundary = (car_cnt_q == CAR_LAST);

  // Carrier phase counter and ramp prescaler
  always_comb begin
    car_cnt_d   = boundary ? '0 : car_cnt_q + 1'b1;
    presc_cnt_d = presc_cnt_q;
    tick        = 1'b0;
    if (!en) begin
      presc_cnt_d = '0;
    end else if (boundary) begin
      if (presc_cnt_q == presc) begin
        presc_cnt_d = '0;
        tick        = 1'b1;
      end else begin
        presc_cnt_d = presc_cnt_q + 1'b1;
      end
    end
  end

  // Step limited to the remaining distance so the ramp never overshoots
  always_comb begin
    diff   = signed'({1'b0, target}) - signed'({1'b0, duty_q});
    mag    = (diff < 0) ? -diff : diff;
    step_s = signed'({{(DW-2){1'b0}}, step});
    inc    = (mag < step_s) ? mag : step_s;
    duty_d = duty_q;
    if (tick) begin
      if (diff > 0) begin
        duty_d = duty_q + inc[DW-1:0];
      end else if (diff < 0) begin
        duty_d = duty_q - inc[DW-1:0];
      end
    end
    upd_strobe_d = tick && (duty_d != duty_q);
  end

  always_comb begin
    bal_ext    = {{(DW-1){bal_off[2]}}, bal_off};
    d2_sum     = signed'({2'b00, duty_d}) + bal_ext;
    d2_clamped = d2_sum[DW-1:0];
    if (d2_sum < 0) begin
      d2_clamped = '0;
    end else if (d2_sum > DUTY_MAX) begin
      d2_clamped = DUTY_MAX[DW-1:0];
    end
    d1_d = d1_q;
    d2_d = d2_q;
    if (en && boundary) begin
      d1_d = duty_d;
      d2_d = d2_clamped;
    end
  end

  // Direction is re-derived from the post-step duty at every valley
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (boundary) begin
      if (target > duty_d) begin
        state_d = RAMP_UP;
      end else if (target < duty_d) begin
        state_d = RAMP_DOWN;
      end else begin
        state_d = LOCKED;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      car_cnt_q    <= '0;
      presc_cnt_q  <= '0;
      duty_q       <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      upd_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      car_cnt_q    <= car_cnt_d;
      presc_cnt_q  <= presc_cnt_d;
      duty_q       <= duty_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      upd_strobe_q <= upd_strobe_d;
    end
  end

  assign d1         = d1_q;
  assign d2         = d2_q;
  assign upd_strobe = upd_strobe_q;
  assign at_target  = (d1_q == target);
  assign busy       = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

endmodule

// File: doc/duty_ramp_controller.md
Name: duty_ramp_controller

Overview:
- Upstream feeder of the PS-PWM modulator.
- Produces the 6-bit duty words d1/d2 that the comparators test against the 6-bit triangular carriers.
- Ramps a sampled duty register toward an externally supplied target at a programmable rate, which prevents step changes from disturbing the flying capacitor.
- Duty words change only at the 0-phase carrier valley, so comparator outputs never glitch mid-period.
- d2 carries a signed capacitor-balance offset relative to d1.

Parameters:
- DW, 6, duty/carrier word width.
- CARRIER_PERIOD, 126, clocks per triangular carrier period (0→63→0 at one step per clock).
- PRESC_W, 8, width of the ramp prescaler.

Ports:
- clk  input  1  modulator clock, same clock as the signal generators.
- RST  input  1  asynchronous, active-high reset.
- en  input  1  ramp enable; low freezes the duty and clears the prescaler.
- target  input  DW  requested duty, unsigned 0..63.
- step  input  3  duty increment per ramp tick, 0..7; 0 freezes the duty.
- presc  input  PRESC_W  ramp ticks occur every presc+1 carrier boundaries.
- bal_off  input  3  signed two's-complement offset applied to d2, range -4..+3.
- d1  output  DW  duty word for comparator 1 (registered).
- d2  output  DW  duty word for comparator 2 (registered, clamped).
- upd_strobe  output  1  one-cycle pulse in the cycle the new ramped value first appears on d1.
- at_target  output  1  combinational: d1 == target.
- busy  output  1  state is RAMP_UP or RAMP_DOWN.

Behaviour:
- Reset (async, RST=1):
  - car_cnt=0, presc_cnt=0, duty=0, d1=0, d2=0, upd_strobe=0, state=IDLE.
  - Outputs go to 0 immediately, including mid-ramp.
  - car_cnt=0 coincides with the 0-phase triangle valley because both blocks share RST.
- Carrier counter:
  - car_cnt increments every clk and wraps CARRIER_PERIOD-1 → 0.
  - The counter runs regardless of en.
- Boundary: boundary = (car_cnt == CARRIER_PERIOD-1). All duty, state, d1 and d2 updates occur only on a boundary clock edge, so new values are visible from car_cnt==0.
- Prescaler:
  - On a boundary edge with en=1: if presc_cnt == presc, then presc_cnt←0 and tick=1; otherwise presc_cnt←presc_cnt+1.
  - If en=0 at any edge, presc_cnt←0.
- Ramp step on tick (en=1):
  - diff = target - duty, computed as a DW+1-bit signed value.
  - If diff>0: duty←duty+min(step,diff).
  - If diff<0: duty←duty-min(step,-diff).
  - Never overshoots target. step=0 leaves duty unchanged.
- Output update on every boundary edge with en=1:
  - d1←next duty.
  - d2←clamp(next duty + sign-extended bal_off, 0, 63), computed in an 8-bit signed domain.
  - A bal_off change therefore takes effect at the next boundary even without a tick.
- upd_strobe: registered; high for exactly one cycle (car_cnt==0) after a tick edge that changed duty. It stays low for ticks that leave duty unchanged.
- en=0: duty, d1 and d2 hold their values. State becomes IDLE at the next edge.
- FSM, evaluated at boundary edges using next duty vs target:
  - IDLE →(en=1) RAMP_UP if target>duty, RAMP_DOWN if target<duty, else LOCKED.
  - RAMP_UP/RAMP_DOWN → LOCKED when duty reaches target.
  - LOCKED → RAMP_UP/RAMP_DOWN when target moves away.
  - A target reversal mid-ramp switches directly between RAMP_UP and RAMP_DOWN.
  - Any state →(en=0) IDLE, applied on any edge, not only at boundaries.
- Timing of inputs:
  - target and step are sampled only at tick edges; changes between ticks have no effect until the next tick.
  - Simultaneous tick and en falling: en=0 wins, no update.
- Latency:
  - First d1 change occurs at most (presc+1)·CARRIER_PERIOD clocks after en rises.
  - Full ramp takes ceil(|target-duty|/step) ticks.

Test Plan:
- Reset: assert RST mid-run with d1=24 → d1=d2=0, upd_strobe=0, state IDLE asynchronously; after release car_cnt counts 0,1,…,125,0.
- Ramp up: en=1, target=40, step=4, presc=0, bal_off=0 → d1 sequence 4,8,…,40, changing only when car_cnt goes 125→0 (every 126 clk); 10 upd_strobe pulses; then LOCKED, at_target=1, busy=0.
- No overshoot / reversal: from d1=40 set target=37, step=4 → d1=37 after one tick. Mid-ramp change of target from 50 to 10 → state RAMP_UP→RAMP_DOWN at the next boundary.
- Prescaler: presc=3, step=1, target=5 from 0 → d1 increments once every 504 clk; reaches 5 after 2520 clk.
- Clamp: d1=62, bal_off=+3 → d2=63. d1=1, bal_off=-4 (3'b100) → d2=0. Changing bal_off alone updates d2 at the next boundary with no upd_strobe.
- Enable/freeze: drop en during RAMP_UP at d1=20 → d1 holds 20, state IDLE, presc_cnt=0. step=0 with en=1 → d1 constant, no upd_strobe.
